aq_djpeg_idct_rdseq: RTL and testbench

Read-side sequencer for the IDCT transpose buffer (aq_djpeg_idctb).
- Watches the buffer's block-ready flag and drives its read strobe and 5-bit read address (0..31) for each block.
- Absorbs the buffer's 1-cycle registered read latency.
- Presents each coefficient pair downstream over a valid/ready handshake with full backpressure support.
- Sits between the idctb buffer and the second IDCT pass / colour stage.

---
 rtl/aq_djpeg_pkg.sv | 19 +
 rtl/aq_djpeg_idct_rdfifo.sv | 62 ++++++
 rtl/aq_djpeg_idct_rdseq.sv | 132 +++++++++++++
 tb/tb_aq_djpeg_idct_rdseq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_djpeg_pkg.sv
`default_nettype none
// ==========================================================================
// aq_djpeg_pkg: shared states and constants for the IDCT read-side sequencer
// Rev 1.0
// ==========================================================================
package aq_djpeg_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } rdseq_state_t;

  localparam int         BLOCK_WORDS = 32;
  localparam logic [4:0] LAST_ADDR   = 5'h1F;
  localparam int         LEVEL_SHIFT = 128;
  localparam int         PIX_MAX     = 255;

endpackage
`default_nettype wire

// File: rtl/aq_djpeg_idct_rdfifo.sv
`default_nettype none
// ==========================================================================
// aq_djpeg_idct_rdfifo: 2-entry synchronous FIFO with flush, head always visible
// Rev 1.0
// ==========================================================================
module aq_djpeg_idct_rdfifo #(
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared only by reset; a flush just empties the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/aq_djpeg_idct_rdseq.sv
`default_nettype none
// ==========================================================================
// aq_djpeg_idct_rdseq: idctb read sequencer, valid/ready pair output.
// Option AQ_DJPEG_IDCT_RDSEQ_CLIP_EN: level shift + clip to 0..255. Rev 1.0
// ==========================================================================
module aq_djpeg_idct_rdseq
  import aq_djpeg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DataInit,
  input  logic              BufEnable,
  output logic              BufRead,
  output logic [ADDR_W-1:0] BufAddress,
  input  logic [DATA_W-1:0] BufDataA,
  input  logic [DATA_W-1:0] BufDataB,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutDataA,
  output logic [DATA_W-1:0] OutDataB,
  output logic [ADDR_W-1:0] OutIndex,
  output logic              OutLast,
  output logic              Busy
);

  localparam int FIFO_W = 2*DATA_W + ADDR_W + 1;

  rdseq_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q;
  logic              inflight_q, inflight_d;
  logic              pop;
  logic              credit_ok;
  logic [2:0]        credit_sum;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] lane_a, lane_b;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

  assign pop        = OutValid && OutReady;
  // Entries held plus the read still in flight must fit after this cycle's pop.
  assign credit_sum = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight_q};
  assign credit_ok  = (credit_sum < 3'd2);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    inflight_d = 1'b0;
    BufRead    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (BufEnable) state_d = S_READ;
      end
      S_READ: begin
        BufRead = BufEnable && credit_ok;
        state_d = BufEnable ? S_READ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (BufRead) begin
      inflight_d = 1'b1;
      addr_d     = (addr_q == ADDR_W'(BLOCK_WORDS-1)) ? '0 : addr_q + ADDR_W'(1);
    end
    // A read strobed alongside DataInit is dropped by never marking it in flight.
    if (DataInit) begin
      state_d    = S_IDLE;
      addr_d     = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      if (BufRead) idx_q <= addr_q;
    end
  end

`ifdef AQ_DJPEG_IDCT_RDSEQ_CLIP_EN
  function automatic logic [DATA_W-1:0] clip_lane(input logic [DATA_W-1:0] d);
    logic signed [DATA_W:0] sum;
    sum = $signed({d[DATA_W-1], d}) + $signed((DATA_W+1)'(LEVEL_SHIFT));
    if (sum[DATA_W])
      clip_lane = '0;
    else if (sum > $signed((DATA_W+1)'(PIX_MAX)))
      clip_lane = DATA_W'(PIX_MAX);
    else
      clip_lane = sum[DATA_W-1:0];
  endfunction

  assign lane_a = clip_lane(BufDataA);
  assign lane_b = clip_lane(BufDataB);
`else
  assign lane_a = BufDataA;
  assign lane_b = BufDataB;
`endif

  assign fifo_wdata = {lane_a, lane_b, idx_q, (idx_q == ADDR_W'(LAST_ADDR))};

  aq_djpeg_idct_rdfifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (DataInit),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign BufAddress = addr_q;
  assign OutValid   = (fifo_count != 2'd0);
  assign OutDataA   = fifo_rdata[FIFO_W-1 -: DATA_W];
  assign OutDataB   = fifo_rdata[ADDR_W+1 +: DATA_W];
  assign OutIndex   = fifo_rdata[1 +: ADDR_W];
  assign OutLast    = fifo_rdata[0];
  // A block paused mid-way (address not back at 0) still counts as in progress.
  assign Busy       = (state_q == S_READ) || inflight_q || OutValid || (addr_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_aq_djpeg_idct_rdseq.sv
`default_nettype none
// ==========================================================================
// tb_aq_djpeg_idct_rdseq: directed bench with idctb read-port model. Rev 1.0
// ==========================================================================
module tb_aq_djpeg_idct_rdseq;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic DataInit = 1'b0;
  logic OutReady = 1'b1;
  logic en_mask = 1'b0;
  logic BufEnable, BufRead, OutValid, OutLast, Busy;
  logic [ADDR_W-1:0] BufAddress, OutIndex;
  logic [DATA_W-1:0] BufDataA = '0;
  logic [DATA_W-1:0] BufDataB = '0;
  logic [DATA_W-1:0] OutDataA, OutDataB;

  int blocks_added = 0;
  int blocks_done  = 0;
  logic [DATA_W-1:0] datA [32];
  logic [DATA_W-1:0] datB [32];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] idx;
    logic              last;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pop_t;
  pop_t pops [$];
  int   rd_cyc [$];

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] exp_clip;
    logic [DATA_W-1:0] exp_pass;
  } vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign BufEnable = (blocks_added != blocks_done) && !en_mask;

  aq_djpeg_idct_rdseq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .DataInit   (DataInit),
    .BufEnable  (BufEnable),
    .BufRead    (BufRead),
    .BufAddress (BufAddress),
    .BufDataA   (BufDataA),
    .BufDataB   (BufDataB),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutDataA   (OutDataA),
    .OutDataB   (OutDataB),
    .OutIndex   (OutIndex),
    .OutLast    (OutLast),
    .Busy       (Busy)
  );

  // Buffer read port: registered read, bank advances on the read of word 31.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      blocks_done <= blocks_added;
    end else begin
      if (BufRead) begin
        BufDataA <= datA[BufAddress];
        BufDataB <= datB[BufAddress] + DATA_W'(blocks_done * 1000);
      end
      if (DataInit) blocks_done <= blocks_added;
      else if (BufRead && BufAddress == 5'd31) blocks_done <= blocks_done + 1;
    end
  end

  always @(negedge clk) begin
    pop_t p;
    if (rst && BufRead) rd_cyc.push_back(cyc);
    if (rst && OutValid && OutReady) begin
      p.cyc = cyc; p.idx = OutIndex; p.last = OutLast; p.a = OutDataA; p.b = OutDataB;
      pops.push_back(p);
    end
  end

  function automatic logic [DATA_W-1:0] xf(input logic [DATA_W-1:0] d);
`ifdef AQ_DJPEG_IDCT_RDSEQ_CLIP_EN
    int v;
    v = int'($signed(d)) + 128;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return DATA_W'(v);
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int target, input int budget, input string tag);
    int n = 0;
    while (pops.size() < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_pop_count"}, pops.size(), target);
  endtask

  task automatic wait_head(input int idx, input string tag);
    int n = 0;
    while (!(OutValid && OutIndex == ADDR_W'(idx)) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_head"}, {OutValid, OutIndex}, {1'b1, ADDR_W'(idx)});
  endtask

  task automatic check_stream(input string tag, input int base, input int n, input int bank0);
    for (int k = 0; k < n; k++) begin
      int i;
      int bank;
      logic [2*DATA_W+ADDR_W:0] act, exp;
      i = k % 32;
      bank = bank0 + k / 32;
      exp = {ADDR_W'(i), (i == 31), xf(datA[i]), xf(datB[i] + DATA_W'(bank * 1000))};
      if (base + k < pops.size())
        act = {pops[base+k].idx, pops[base+k].last, pops[base+k].a, pops[base+k].b};
      else
        act = '1;
      check($sformatf("%s_pair%0d", tag, k), act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_BufRead"}, BufRead, 0);
    check({tag, "_BufAddress"}, BufAddress, 0);
    check({tag, "_OutValid"}, OutValid, 0);
    check({tag, "_OutDataA"}, OutDataA, 0);
    check({tag, "_OutDataB"}, OutDataB, 0);
    check({tag, "_OutIndex"}, OutIndex, 0);
    check({tag, "_OutLast"}, OutLast, 0);
    check({tag, "_Busy"}, Busy, 0);
  endtask

  initial begin
    int base, rbase, bank0, en_cyc, frozen_bad, r0;

    tbl[0] = '{din: 16'hFF38, exp_clip: 16'd0,   exp_pass: 16'hFF38};
    tbl[1] = '{din: 16'd127,  exp_clip: 16'd255, exp_pass: 16'd127};
    tbl[2] = '{din: 16'd300,  exp_clip: 16'd255, exp_pass: 16'd300};
    tbl[3] = '{din: 16'd0,    exp_clip: 16'd128, exp_pass: 16'd0};
    for (int i = 0; i < 32; i++) begin
      datA[i] = DATA_W'(i);
      datB[i] = DATA_W'(i + 100);
    end

    #1 rst = 1'b0;
    #2 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();

    // Level shift / clip table, first block so bank offset is zero
    for (int k = 0; k < 4; k++) begin
      datA[k] = tbl[k].din;
      datB[k] = tbl[3-k].din;
    end
    base = pops.size();
    blocks_added++;
    wait_pops(base + 32, 200, "clip");
    for (int k = 0; k < 4; k++) begin
`ifdef AQ_DJPEG_IDCT_RDSEQ_CLIP_EN
      check($sformatf("clip_A%0d", k), pops[base+k].a, tbl[k].exp_clip);
      check($sformatf("clip_B%0d", k), pops[base+k].b, tbl[3-k].exp_clip);
`else
      check($sformatf("pass_A%0d", k), pops[base+k].a, tbl[k].exp_pass);
      check($sformatf("pass_B%0d", k), pops[base+k].b, tbl[3-k].exp_pass);
`endif
    end
    for (int k = 0; k < 4; k++) begin
      datA[k] = DATA_W'(k);
      datB[k] = DATA_W'(k + 100);
    end
    repeat (4) tick();

    // Single block, ready held high
    base = pops.size(); rbase = rd_cyc.size(); bank0 = blocks_done; en_cyc = cyc;
    blocks_added++;
    wait_pops(base + 32, 200, "t1");
    repeat (4) tick();
    check("t1_reads", rd_cyc.size() - rbase, 32);
    check("t1_read_latency", rd_cyc[rbase] - en_cyc, 1);
    check("t1_valid_latency", pops[base].cyc - rd_cyc[rbase], 2);
    check("t1_contiguous", pops[base+31].cyc - pops[base].cyc, 31);
    check_stream("t1", base, 32, bank0);
    check("t1_idle_busy", Busy, 0);

    // Backpressure from index 5 for 10 cycles
    base = pops.size(); rbase = rd_cyc.size(); bank0 = blocks_done;
    blocks_added++;
    wait_head(5, "t2");
    OutReady = 1'b0;
    frozen_bad = 0;
    repeat (10) begin
      tick();
      if (OutIndex != 5'd5 || OutDataA != xf(datA[5]) || !OutValid) frozen_bad++;
    end
    check("t2_frozen", frozen_bad, 0);
    check("t2_outstanding", (rd_cyc.size() - rbase) - (pops.size() - base), 2);
    check("t2_reads_held", rd_cyc.size() - rbase, 7);
    OutReady = 1'b1;
    wait_pops(base + 32, 200, "t2");
    repeat (4) tick();
    check("t2_reads", rd_cyc.size() - rbase, 32);
    check_stream("t2", base, 32, bank0);

    // Back-to-back blocks
    base = pops.size(); rbase = rd_cyc.size(); bank0 = blocks_done;
    blocks_added += 2;
    wait_pops(base + 64, 300, "t3");
    repeat (4) tick();
    check("t3_reads", rd_cyc.size() - rbase, 64);
    check("t3_read_span", rd_cyc[rbase+63] - rd_cyc[rbase], 63);
    check("t3_pop_span", pops[base+63].cyc - pops[base].cyc, 63);
    check_stream("t3", base, 64, bank0);

    // DataInit with index 17 at the head
    blocks_added++;
    wait_head(17, "t4");
    DataInit = 1'b1;
    tick();
    DataInit = 1'b0;
    check("t4_valid_low", OutValid, 0);
    check("t4_busy_low", Busy, 0);
    check("t4_addr_zero", BufAddress, 0);
    repeat (3) tick();
    check("t4_still_empty", OutValid, 0);
    base = pops.size(); bank0 = blocks_done;
    blocks_added++;
    wait_pops(base + 32, 200, "t4");
    repeat (6) tick();
    check("t4_no_extra", pops.size() - base, 32);
    check_stream("t4", base, 32, bank0);

    // BufEnable dropped mid-block: pause, resume at same address
    base = pops.size(); rbase = rd_cyc.size(); bank0 = blocks_done;
    blocks_added++;
    wait_head(8, "t5");
    en_mask = 1'b1;
    repeat (3) tick();
    r0 = rd_cyc.size();
    repeat (5) tick();
    check("t5_paused", rd_cyc.size() - r0, 0);
    check("t5_busy_paused", Busy, 1);
    en_mask = 1'b0;
    wait_pops(base + 32, 200, "t5");
    repeat (4) tick();
    check("t5_reads", rd_cyc.size() - rbase, 32);
    check_stream("t5", base, 32, bank0);

    // Asynchronous reset mid-block
    blocks_added++;
    wait_head(10, "t6");
    #2 rst = 1'b0;
    #1 check_zero("t6_async");
    @(negedge clk);
    rst = 1'b1;
    r0 = rd_cyc.size(); base = pops.size();
    repeat (5) tick();
    check("t6_no_reads", rd_cyc.size() - r0, 0);
    check("t6_no_pops", pops.size() - base, 0);
    check("t6_busy", Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
